unidade_controle: RTL
=====================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle pulse; starts execution from PC=0 (IDLE or HALT only).
REQ-005 instr  input  32  instruction word from MemoriaInstrucao, valid one cycle after endr.
REQ-006 endr  output  7  instruction word address (program counter).
REQ-007 Ra, Rb, Rw  output  5 each  register-file read ports and write port.
REQ-008 WeR, WeM  output  1 each  register-file write enable and data-memory write enable.
REQ-009 escolhe_entrada1, escolhe_entrada2  output  2 each  ULA input select: 0=doutb, 1=douta, 2=constante.
REQ-010 soma_ou_subtrai, subtraindo  output  1 each  ULA operation enable and subtract select.
REQ-011 constante  output  64  sign-extended immediate.
REQ-012 sel_dinR  output  1  register write source: 0=doutULA, 1=doutM.
REQ-013 busy, done, illegal  output  1 each  running, halted normally, and halted on an illegal opcode.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 Transitions SHALL be as follows.
- IDLE --start--> FETCH
- FETCH -> DECODE
- DECODE: latch instr into IR, then go to EXEC or HALT
- EXEC -> FETCH for ADD, SUB and ADDI
- EXEC -> MEM for LD and SD
- MEM -> WB for LD
- MEM -> FETCH for SD
- WB -> FETCH
REQ-016 Decode SHALL follow RV64I encodings.
- LD: opcode 0000011, funct3 011
- SD: opcode 0100011, funct3 011
- ADD: opcode 0110011, funct3 000, funct7 0000000
- SUB: same as ADD but funct7 0100000
- ADDI: opcode 0010011, funct3 000
REQ-017 instr == 32'h00000000 in DECODE SHALL go to HALT with done=1 and illegal=0.
REQ-018 Any other undecodable word SHALL be handled as set by UC_ILLEGAL_TRAP_EN.
REQ-019 In all states, Ra=IR[19:15] and Rb=IR[24:20]; Rw=IR[11:7].
REQ-020 soma_ou_subtrai SHALL be 1 in EXEC, MEM and WB; subtraindo SHALL be 1 only for SUB.
REQ-021 ADD and SUB SHALL use select1=1 and select2=0.
REQ-022 ADDI, LD and SD SHALL use select1=1, select2=2 and constante=sext(IR[31:20]).
- Exception: SD uses constante=sext({IR[31:25],IR[11:7]}).
REQ-023 ULA selects and constante SHALL be held stable through EXEC, MEM and WB so the memory address does not change.
REQ-024 WeR SHALL be 1 in EXEC for ADD/SUB/ADDI with sel_dinR=0, and in WB for LD with sel_dinR=1.
REQ-025 WeR SHALL be 0 in every other state.
REQ-026 WeR SHALL be forced to 0 whenever Rw==0, so x0 is never written.
REQ-027 WeM SHALL be 1 only in MEM for SD; WeM and WeR SHALL never both be 1.
REQ-028 endr SHALL increment by 1 on leaving EXEC (ALU ops), MEM (SD) or WB (LD), and SHALL wrap from 127 to 0.
REQ-029 Instruction latency SHALL be 3 cycles for ALU ops, 4 for SD and 5 for LD, counted FETCH to next FETCH.
REQ-030 busy SHALL be 1 in FETCH through WB; done and illegal SHALL hold in HALT until start or reset.
REQ-031 start SHALL be ignored in states other than IDLE and HALT.
REQ-032 start in HALT SHALL clear done and illegal, set endr=0 and go to FETCH.

Reset
REQ-033 rst_n low SHALL immediately force the following, aborting any instruction in flight:
- state=IDLE, endr=0, IR=0
- all enables, selects, constante, sel_dinR, busy, done and illegal = 0
REQ-034 A write SHALL never be asserted in the cycle rst_n deasserts.

Configuration
REQ-035 With UC_ILLEGAL_TRAP_EN defined, an undecodable opcode in DECODE SHALL go to HALT with illegal=1 and done=1, and endr SHALL be left unchanged.
REQ-036 Without UC_ILLEGAL_TRAP_EN, an undecodable opcode SHALL be treated as a NOP.
- DECODE -> FETCH with endr+1 and no enables; illegal stays 0.

Structure
REQ-037 Package uc_pkg SHALL hold the state encoding, the opcode/funct3/funct7 constants, the ULA select codes (B=0, A=1, C=2) and the sel_dinR codes.
REQ-038 The combinational decoder SHALL be a sub-module uc_decoder (IR in; op class, immediate and illegal flag out).
- The FSM and PC stay in unidade_controle.

Verification
REQ-039 Program ld x1,1(x0); ld x2,2(x0); sd x1,5(x0); halt, with mem[1]=7 and mem[2]=3 -> x1=7, x2=3, mem[5]=7, done=1, endr=3, 5+5+4 cycles.
REQ-040 add x3,x1,x2 then sub x4,x1,x2 with x1=7, x2=3 -> x3=10, x4=4; each instruction is 3 cycles; subtraindo=1 only during the sub.
REQ-041 addi x5,x1,-2 (imm 12'hFFE) with x1=7 -> constante=64'hFFFF_FFFF_FFFF_FFFE, x5=5; sd with offset -8 -> constante=-8.
REQ-042 add x0,x1,x2 -> WeR stays 0 and x0 remains 0; a 128-instruction ADDI loop -> endr wraps 127 to 0.
REQ-043 Word 32'hFFFFFFFF -> with UC_ILLEGAL_TRAP_EN: HALT, illegal=1; without it: skipped, endr+1.
REQ-044 rst_n low during the MEM state of an sd -> WeM drops within the same cycle, state=IDLE, endr=0; start then reruns from address 0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle RV64I subset control unit: FSM states,
// instruction fields, ULA input select codes and register write-source codes.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } uc_state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_SD   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_ADDI = 3'd5,
        OP_HALT = 3'd6
    } uc_op_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_ADD = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [1:0] SEL_B = 2'd0;
    localparam logic [1:0] SEL_A = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    localparam logic DIN_ULA = 1'b0;
    localparam logic DIN_MEM = 1'b1;

    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational instruction decoder: classifies an instruction word and
// builds its sign-extended immediate (I-type, or S-type for stores).
module uc_decoder
    import uc_pkg::*;
(
    input  logic [31:0] i_ir,
    output uc_op_t      o_op,
    output logic [63:0] o_imm,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_ir[6:0];
    assign w_funct3 = i_ir[14:12];
    assign w_funct7 = i_ir[31:25];

    always_comb begin
        o_op      = OP_NONE;
        o_imm     = '0;
        o_illegal = 1'b0;
        if (i_ir == 32'h0000_0000) begin
            o_op = OP_HALT;
        end else begin
            case (w_opcode)
                OPC_LOAD: begin
                    if (w_funct3 == F3_D) begin
                        o_op  = OP_LD;
                        o_imm = sext12(i_ir[31:20]);
                    end
                end
                OPC_STORE: begin
                    if (w_funct3 == F3_D) begin
                        o_op  = OP_SD;
                        o_imm = sext12({i_ir[31:25], i_ir[11:7]});
                    end
                end
                OPC_OP: begin
                    if (w_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
                        o_op = OP_ADD;
                    end else if (w_funct3 == F3_ADD && w_funct7 == F7_SUB) begin
                        o_op = OP_SUB;
                    end
                end
                OPC_OPIMM: begin
                    if (w_funct3 == F3_ADD) begin
                        o_op  = OP_ADDI;
                        o_imm = sext12(i_ir[31:20]);
                    end
                end
                default: ;
            endcase
            o_illegal = (o_op == OP_NONE);
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit (FSM + PC) for LD/SD/ADD/SUB/ADDI. Define
// UC_ILLEGAL_TRAP_EN to halt on undecodable words instead of skipping them.
module unidade_controle
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    output logic [6:0]  endr,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic        WeR,
    output logic        WeM,
    output logic [1:0]  escolhe_entrada1,
    output logic [1:0]  escolhe_entrada2,
    output logic        soma_ou_subtrai,
    output logic        subtraindo,
    output logic [63:0] constante,
    output logic        sel_dinR,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output uc_state_t   o_dbg_state
);

    uc_state_t   r_state;
    logic [31:0] r_ir;
    logic [6:0]  r_pc;
    logic        r_we_r;
    logic        r_we_m;
    logic        r_alu_en;
    logic        r_sub;
    logic [1:0]  r_sel1;
    logic [1:0]  r_sel2;
    logic [63:0] r_const;
    logic        r_sel_din;
    logic        r_busy;
    logic        r_done;
    logic        r_illegal;

    logic [31:0] w_dec_in;
    uc_op_t      w_op;
    logic [63:0] w_imm;
    logic        w_illegal;
    logic        w_is_alu;
    logic        w_is_mem;
    logic        w_leave;

    // While in DECODE the incoming word is classified; afterwards the latched IR.
    assign w_dec_in = (r_state == ST_DECODE) ? instr : r_ir;

    uc_decoder u_decoder (
        .i_ir      (w_dec_in),
        .o_op      (w_op),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ADDI);
    assign w_is_mem = (w_op == OP_LD) || (w_op == OP_SD);
    assign w_leave  = ((r_state == ST_EXEC) && w_is_alu) ||
                      ((r_state == ST_MEM) && (w_op == OP_SD)) ||
                      (r_state == ST_WB);

    // start is a one-cycle request, accepted only in IDLE or HALT; elsewhere it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ir      <= '0;
            r_pc      <= '0;
            r_we_r    <= 1'b0;
            r_we_m    <= 1'b0;
            r_alu_en  <= 1'b0;
            r_sub     <= 1'b0;
            r_sel1    <= SEL_B;
            r_sel2    <= SEL_B;
            r_const   <= '0;
            r_sel_din <= DIN_ULA;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state   <= ST_FETCH;
                        r_pc      <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_ir <= instr;
                    if (w_op == OP_HALT) begin
                        r_state <= ST_HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_illegal) begin
`ifdef UC_ILLEGAL_TRAP_EN
                        r_state   <= ST_HALT;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_illegal <= 1'b1;
`else
                        r_state <= ST_FETCH;
                        r_pc    <= r_pc + 7'd1;
`endif
                    end else begin
                        r_state   <= ST_EXEC;
                        r_alu_en  <= 1'b1;
                        r_sub     <= (w_op == OP_SUB);
                        r_sel1    <= SEL_A;
                        r_sel2    <= w_is_mem || (w_op == OP_ADDI) ? SEL_C : SEL_B;
                        r_const   <= w_imm;
                        r_sel_din <= DIN_ULA;
                        r_we_r    <= w_is_alu && (instr[11:7] != 5'd0);
                    end
                end
                ST_EXEC: begin
                    if (w_is_mem) begin
                        r_state <= ST_MEM;
                        r_we_m  <= (w_op == OP_SD);
                    end
                end
                ST_MEM: begin
                    if (w_op == OP_LD) begin
                        r_state   <= ST_WB;
                        r_sel_din <= DIN_MEM;
                        r_we_r    <= (r_ir[11:7] != 5'd0);
                    end
                end
                ST_WB: ;
                default: r_state <= ST_IDLE;
            endcase

            // Retiring an instruction: advance the PC and drop every datapath control.
            if (w_leave) begin
                r_state   <= ST_FETCH;
                r_pc      <= r_pc + 7'd1;
                r_we_r    <= 1'b0;
                r_we_m    <= 1'b0;
                r_alu_en  <= 1'b0;
                r_sub     <= 1'b0;
                r_sel1    <= SEL_B;
                r_sel2    <= SEL_B;
                r_const   <= '0;
                r_sel_din <= DIN_ULA;
            end
        end
    end

    assign endr             = r_pc;
    assign Ra               = r_ir[19:15];
    assign Rb               = r_ir[24:20];
    assign Rw               = r_ir[11:7];
    assign WeR              = r_we_r;
    assign WeM              = r_we_m;
    assign escolhe_entrada1 = r_sel1;
    assign escolhe_entrada2 = r_sel2;
    assign soma_ou_subtrai  = r_alu_en;
    assign subtraindo       = r_sub;
    assign constante        = r_const;
    assign sel_dinR         = r_sel_din;
    assign busy             = r_busy;
    assign done             = r_done;
    assign illegal          = r_illegal;
    assign o_dbg_state      = r_state;

endmodule
